regfile: RTL and testbench



---
 rtl/regfile.sv | 110 +++++++++++
 tb/tb_regfile.sv | 133 +++++++++++++
 2 files changed

// File: rtl/regfile.sv
// regfile: 2-read / 1-write register file. reg[0] is hardwired to zero,
// the read ports are registered with a valid strobe and see same-cycle
// writes through a bypass.

// One registered read port. It selects zero, the bypass data or the stored
// word, and loads it when a read is requested.
module regfile_rdport #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [WIDTH-1:0] i_mem_q,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_rvalid
);
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] r_rdata;
  logic             r_rvalid;

  // Address 0 wins over the bypass, so a write to r0 never leaks into a read.
  always_comb begin
    w_next = i_mem_q;
    if (i_raddr == '0)
      w_next = '0;
    else if (i_we && (i_waddr == i_raddr))
      w_next = i_wdata;
  end

  // Load data on a request. Without a request the data holds and valid drops.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= i_re;
      if (i_re) r_rdata <= w_next;
    end
  end

  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;
endmodule

module regfile #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re_a,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  output logic             rvalid_a,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rvalid_b
);
  localparam int NPORTS = 2;

  logic [DEPTH-1:0][WIDTH-1:0]  r_mem;
  logic [NPORTS-1:0]            w_re;
  logic [NPORTS-1:0][AW-1:0]    w_raddr;
  logic [NPORTS-1:0][WIDTH-1:0] w_rdata;
  logic [NPORTS-1:0]            w_rvalid;

  // Storage array. Entry 0 is never written, so it stays at its reset value of 0.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_mem <= '0;
    end else if (we) begin
      for (int i = 1; i < DEPTH; i++)
        if (waddr == AW'(i)) r_mem[i] <= wdata;
    end
  end

  assign w_re    = {re_b, re_a};
  assign w_raddr = {raddr_b, raddr_a};

  // The read ports are identical, so they are built from one port module.
  for (genvar p = 0; p < NPORTS; p++) begin : g_rd
    regfile_rdport #(.WIDTH(WIDTH), .AW(AW)) u_rd (
      .clk     (clk),
      .clr_n   (clr_n),
      .i_re    (w_re[p]),
      .i_raddr (w_raddr[p]),
      .i_we    (we),
      .i_waddr (waddr),
      .i_wdata (wdata),
      .i_mem_q (r_mem[w_raddr[p]]),
      .o_rdata (w_rdata[p]),
      .o_rvalid(w_rvalid[p])
    );
  end

  assign rdata_a  = w_rdata[0];
  assign rvalid_a = w_rvalid[0];
  assign rdata_b  = w_rdata[1];
  assign rvalid_b = w_rvalid[1];
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed and random stimulus for regfile. The bench checks
// every cycle against a write-first array model.
module tb_regfile;
  localparam int W  = 32;
  localparam int AW = 5;
  localparam int D  = 32;

  logic          clk = 1'b0;
  logic          clr_n, we, re_a, re_b;
  logic [AW-1:0] waddr, raddr_a, raddr_b;
  logic [W-1:0]  wdata, rdata_a, rdata_b;
  logic          rvalid_a, rvalid_b;

  always #5 clk = ~clk;

  regfile #(.WIDTH(W), .DEPTH(D), .AW(AW)) dut (
    .clk(clk), .clr_n(clr_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b)
  );

  // Reference model: the architectural register array. A write lands first
  // and the read then sees the updated array. This gives the bypass behaviour,
  // and index 0 is never written.
  logic [W-1:0] mem [D];
  logic [W-1:0] exp_ra, exp_rb;
  logic         exp_va, exp_vb;
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".rdata_a"},  rdata_a,  exp_ra);
    chk({tag, ".rvalid_a"}, W'(rvalid_a), W'(exp_va));
    chk({tag, ".rdata_b"},  rdata_b,  exp_rb);
    chk({tag, ".rvalid_b"}, W'(rvalid_b), W'(exp_vb));
  endtask

  task automatic model_clear();
    for (int i = 0; i < D; i++) mem[i] = '0;
    exp_ra = '0; exp_rb = '0; exp_va = 1'b0; exp_vb = 1'b0;
  endtask

  task automatic drive(input logic iwe, input int iwa, input logic [W-1:0] iwd,
                       input logic ira, input int iaa, input logic irb, input int iab);
    we = iwe; waddr = AW'(iwa); wdata = iwd;
    re_a = ira; raddr_a = AW'(iaa); re_b = irb; raddr_b = AW'(iab);
  endtask

  // Advance one clock edge with the current inputs, then check the outputs.
  task automatic cycle(input string tag);
    if (!clr_n) begin
      model_clear();
    end else begin
      if (we && waddr != 0) mem[waddr] = wdata;
      exp_va = re_a;
      exp_vb = re_b;
      if (re_a) exp_ra = mem[raddr_a];
      if (re_b) exp_rb = mem[raddr_b];
    end
    @(posedge clk); #1;
    check_outs(tag);
  endtask

  initial begin
    clr_n = 1'b1;
    drive(1, 9, 32'hFFFF_FFFF, 1, 9, 1, 9);
    model_clear();
    #2 clr_n = 1'b0;
    #1 check_outs("rst_async");

    // Hold reset across edges while write and read requests are active.
    for (int i = 0; i < 3; i++) cycle("rst_hold");
    clr_n = 1'b1;
    for (int i = 1; i < D; i++) begin
      drive(0, 0, '0, 1, i, 1, D - i);
      cycle("post_rst_read");
    end

    // Write, then read back on the next cycle.
    drive(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0); cycle("wr_r5");
    drive(0, 0, '0, 1, 5, 0, 0);            cycle("rd_r5");

    // Bypass: write r7 and read it on both ports in the same cycle.
    drive(1, 7, 32'h1234_5678, 1, 7, 1, 7); cycle("bypass_r7");

    // Zero register, with and without a write in the same cycle.
    drive(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0); cycle("wr_r0");
    drive(0, 0, '0, 1, 0, 1, 0);            cycle("rd_r0");
    drive(1, 0, 32'hFFFF_FFFF, 1, 0, 1, 0); cycle("wr_rd_r0");

    // Streaming: fill the array, then read back-to-back in both directions.
    for (int i = 1; i < D; i++) begin
      drive(1, i, W'(i * 3), 0, 0, 0, 0);
      cycle("fill");
    end
    for (int i = 1; i < D; i++) begin
      drive(0, 0, '0, 1, i, 1, D - i);
      cycle("stream");
    end
    drive(0, 0, '0, 0, 0, 0, 0); cycle("stream_end");

    // Assert reset asynchronously while reads are streaming.
    drive(1, 3, 32'hA5A5_A5A5, 0, 0, 0, 0); cycle("wr_r3");
    drive(0, 0, '0, 1, 3, 1, 3);
    cycle("rd_r3_0");
    cycle("rd_r3_1");
    #2 clr_n = 1'b0;
    #1 model_clear();
    check_outs("mid_rst");
    #1 clr_n = 1'b1;
    cycle("rd_r3_after_rst");

    // Random traffic. Addresses are confined to a small range so that
    // writes and reads often collide on the same register.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom), int'($urandom_range(0, 7)), W'($urandom),
            1'($urandom), int'($urandom_range(0, 7)),
            1'($urandom), int'($urandom_range(0, 7)));
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
